seq_pattern_gen: RTL and testbench



---
 rtl/seq_pattern_gen_if.sv | 35 +++
 rtl/seq_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_seq_pattern_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_gen_if
// Description : Request / serial-output bundle for seq_pattern_gen.
//               master = requester (drives start and the pattern fields),
//               slave  = generator (drives the serial stream and status).
//               The repeat count is carried on 'repeats' because 'repeat'
//               is a reserved word.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_pattern_gen_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic [REP_W-1:0] repeats;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, length, repeats,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  start, pattern, length, repeats,
        output out, out_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_gen
// Description : Serial bit-pattern transmitter. Captures pattern/length/
//               repeat on a start pulse in IDLE and emits the pattern
//               MSB-first, one bit per clk, repeated back-to-back.
//               Optional feature macro SEQ_GEN_PARITY_EN appends an
//               even-parity bit after every pass.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    seq_pattern_gen_if.slave    sig
);
    localparam int CNT_W = $clog2(PAT_W + 1);
    localparam logic [CNT_W-1:0] C_PAT_W = CNT_W'(PAT_W);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEND   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
`ifdef SEQ_GEN_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd3;
`endif

    logic [1:0]       r_state;
    logic [PAT_W-1:0] r_pat;       // captured pattern, MSB-aligned
    logic [PAT_W-1:0] r_shift;     // bits still to send in this pass
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_bit_cnt;   // bits remaining after the one on 'out'
    logic [REP_W-1:0] r_rep_cnt;
    logic             r_out;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;
`ifdef SEQ_GEN_PARITY_EN
    logic             r_parity;
`endif

    logic [CNT_W-1:0] w_len;
    logic [PAT_W-1:0] w_aligned;
    logic             w_pass_end;

    // Clamp the requested length and left-align the pattern so the first
    // bit to send always sits in the MSB.
    always_comb begin
        w_len = C_PAT_W;
        if (sig.length != '0 && sig.length <= LEN_W'(PAT_W))
            w_len = CNT_W'(sig.length);
        w_aligned = sig.pattern << (C_PAT_W - w_len);
    end

    // A pass ends on the cycle carrying its final bit (the parity bit when
    // parity is enabled).
    always_comb begin
`ifdef SEQ_GEN_PARITY_EN
        w_pass_end = (r_state == S_PARITY);
`else
        w_pass_end = (r_state == S_SEND) && (r_bit_cnt == '0);
`endif
    end

    // Main sequencer; the end-of-pass block after the case overrides the
    // per-state assignments to either reload the next pass or finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pat       <= '0;
            r_shift     <= '0;
            r_len       <= '0;
            r_bit_cnt   <= '0;
            r_rep_cnt   <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    if (sig.start) begin
                        r_pat       <= w_aligned;
                        r_len       <= w_len;
                        r_rep_cnt   <= sig.repeats;
                        r_shift     <= w_aligned << 1;
                        r_bit_cnt   <= w_len - 1'b1;
                        r_out       <= w_aligned[PAT_W-1];
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_SEND;
`ifdef SEQ_GEN_PARITY_EN
                        r_parity    <= ^w_aligned;
`endif
                    end
                end
                S_SEND: begin
                    if (r_bit_cnt != '0) begin
                        r_out     <= r_shift[PAT_W-1];
                        r_shift   <= r_shift << 1;
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
`ifdef SEQ_GEN_PARITY_EN
                    else begin
                        r_out   <= r_parity;
                        r_state <= S_PARITY;
                    end
`endif
                end
`ifdef SEQ_GEN_PARITY_EN
                S_PARITY: begin
                    r_out <= r_parity;
                end
`endif
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_pass_end) begin
                if (r_rep_cnt != '0) begin
                    r_shift     <= r_pat << 1;
                    r_out       <= r_pat[PAT_W-1];
                    r_out_valid <= 1'b1;
                    r_bit_cnt   <= r_len - 1'b1;
                    r_rep_cnt   <= r_rep_cnt - 1'b1;
                    r_state     <= S_SEND;
                end else begin
                    r_out       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= S_FINISH;
                end
            end
        end
    end

    assign sig.out       = r_out;
    assign sig.out_valid = r_out_valid;
    assign sig.busy      = r_busy;
    assign sig.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pattern_gen
// Description : Self-checking bench for seq_pattern_gen. Expected streams
//               are built from pattern/length/repeat as plain bit queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_gen;
    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int REP_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   exp_q[$];

    always #5 clk = ~clk;

    seq_pattern_gen_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

    seq_pattern_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sig   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected serial stream: (rep+1) passes of pattern[L-1..0], each
    // optionally followed by the XOR of its bits.
    function automatic void build(input logic [PAT_W-1:0] pat, input int len, input int rep);
        int  l;
        bit  par;
        exp_q.delete();
        l = (len == 0 || len > PAT_W) ? PAT_W : len;
        for (int p = 0; p <= rep; p++) begin
            par = 1'b0;
            for (int i = l - 1; i >= 0; i--) begin
                exp_q.push_back(pat[i]);
                par ^= pat[i];
            end
`ifdef SEQ_GEN_PARITY_EN
            exp_q.push_back(par);
`endif
        end
    endfunction

    task automatic drive(input logic [PAT_W-1:0] pat, input int len, input int rep);
        bus.pattern = pat;
        bus.length  = LEN_W'(len);
        bus.repeats = REP_W'(rep);
        bus.start   = 1'b1;
    endtask

    // Called one cycle after the capture edge; walks the whole transfer.
    task automatic check_stream(input logic [PAT_W-1:0] pat, input int len, input int rep,
                                input bit scramble, input string tag);
        build(pat, len, rep);
        foreach (exp_q[k]) begin
            chk($sformatf("%s valid[%0d]", tag, k), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("%s out[%0d]", tag, k), {31'b0, bus.out}, {31'b0, exp_q[k]});
            chk($sformatf("%s busy[%0d]", tag, k), {31'b0, bus.busy}, 32'd1);
            chk($sformatf("%s done_early[%0d]", tag, k), {31'b0, bus.done}, 32'd0);
            if (scramble) begin
                bus.pattern = PAT_W'($urandom);
                bus.length  = LEN_W'($urandom);
                bus.repeats = REP_W'($urandom);
            end
            tick();
        end
        chk({tag, " done"}, {31'b0, bus.done}, 32'd1);
        chk({tag, " done_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, " done_out"}, {31'b0, bus.out}, 32'd0);
        chk({tag, " done_busy"}, {31'b0, bus.busy}, 32'd1);
        tick();
        chk({tag, " post_done"}, {31'b0, bus.done}, 32'd0);
        chk({tag, " post_busy"}, {31'b0, bus.busy}, 32'd0);
        chk({tag, " post_valid"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int len, rep;
        logic [PAT_W-1:0] pat;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.length  = '0;
        bus.repeats = '0;
        tick();
        tick();
        chk("rst out", {31'b0, bus.out}, 32'd0);
        chk("rst valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst busy", {31'b0, bus.busy}, 32'd0);
        chk("rst done", {31'b0, bus.done}, 32'd0);
        reset = 1'b0;
        tick();

        // 8'h06 / length 3 / single pass
        drive(8'h06, 3, 0);
        tick();
        bus.start = 1'b0;
        check_stream(8'h06, 3, 0, 1'b1, "p06");

        // three back-to-back passes
        drive(8'h06, 3, 2);
        tick();
        bus.start = 1'b0;
        check_stream(8'h06, 3, 2, 1'b1, "p06r2");

        // length 0 clamps to full width
        drive(8'hA5, 0, 0);
        tick();
        bus.start = 1'b0;
        check_stream(8'hA5, 0, 0, 1'b1, "pA5");

        // start held high: one transfer, then a fresh one from IDLE
        drive(8'h06, 3, 1);
        tick();
        check_stream(8'h06, 3, 1, 1'b0, "hold1");
        tick();
        bus.start = 1'b0;
        check_stream(8'h06, 3, 1, 1'b0, "hold2");

        // reset during the second SEND cycle aborts without done
        drive(8'h06, 3, 0);
        tick();
        bus.start = 1'b0;
        chk("abort bit0", {31'b0, bus.out}, 32'd1);
        tick();
        chk("abort bit1", {31'b0, bus.out}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort valid", {31'b0, bus.out_valid}, 32'd0);
        chk("abort busy", {31'b0, bus.busy}, 32'd0);
        chk("abort done", {31'b0, bus.done}, 32'd0);
        chk("abort out", {31'b0, bus.out}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("abort quiet done[%0d]", i), {31'b0, bus.done}, 32'd0);
            chk($sformatf("abort quiet valid[%0d]", i), {31'b0, bus.out_valid}, 32'd0);
        end

        // reset and start together: start is dropped
        reset = 1'b1;
        drive(8'hFF, 4, 0);
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("rst_start valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_start busy", {31'b0, bus.busy}, 32'd0);
        tick();
        chk("rst_start valid2", {31'b0, bus.out_valid}, 32'd0);

        // randomized transfers, including lengths above PAT_W
        for (int n = 0; n < 20; n++) begin
            pat = PAT_W'($urandom);
            len = int'($urandom_range(0, 15));
            rep = int'($urandom_range(0, 3));
            drive(pat, len, rep);
            tick();
            bus.start = 1'b0;
            check_stream(pat, len, rep, 1'b1, $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
